nor_vector_decoder: RTL and testbench
=====================================

NOR_VECTOR_DECODER -- requirements
Module: nor_vector_decoder

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive valid vectors needed to reach LOCKED (range 1..15).
REQ-002 Parameter FAULT_CNT, default 3: consecutive invalid vectors needed to reach FAULT (range 1..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 clr  in  1  synchronous clear of FSM, run counters and err_count.
REQ-006 in_valid  in  1  in_vec is valid this cycle.
REQ-007 in_ready  out  1  block accepts in_vec this cycle.
REQ-008 in_vec  in  8  gate-result vector indexed [0:7]: y0=~a, y1=~b, y2=nor, y3=and, y4=or, y5=nand, y6=xnor, y7=xor.
REQ-009 out_valid  out  1  decoded result held in output register.
REQ-010 out_ready  in  1  downstream accepts the result.
REQ-011 out_a, out_b  out  1 each  recovered operands.
REQ-012 out_err  out  1  vector is not one of the four legal codes.
REQ-013 state  out  2  FSM state: 0 IDLE, 1 SYNC, 2 LOCKED, 3 FAULT.
REQ-014 err_count  out  8  saturating count of invalid vectors accepted.

Function
REQ-015 Legal codes, listed y0..y7, SHALL be: ab=00 -> 11100110; ab=01 -> 10001101; ab=10 -> 01001101; ab=11 -> 00011010.
REQ-016 Any other in_vec SHALL give out_err=1, out_a=~y0, out_b=~y1.
REQ-017 Handshake: accept occurs when in_valid && in_ready; in_ready = !clr && (!out_valid || out_ready).
REQ-018 Latency: an accepted vector SHALL appear on out_* in the next cycle with out_valid=1.
REQ-019 out_* SHALL hold stable while out_valid && !out_ready; out_valid drops after an out_ready handshake unless a new accept occurs in the same cycle.
REQ-020 Simultaneous accept and output handshake SHALL replace the output register without a bubble (full throughput).
REQ-021 On each accept, good_run and bad_run (4-bit) SHALL update: valid vector -> good_run+1 saturating at 15, bad_run=0; invalid vector -> bad_run+1 saturating at 15, good_run=0.
REQ-022 IDLE -> SYNC on the first accept, with the counters applied to that vector.
REQ-023 SYNC -> LOCKED when updated good_run reaches LOCK_CNT; SYNC -> FAULT when updated bad_run reaches FAULT_CNT.
REQ-024 LOCKED -> FAULT when updated bad_run reaches FAULT_CNT; isolated invalid vectors below the threshold keep LOCKED.
REQ-025 FAULT SHALL be sticky and exit only via clr or rst.
REQ-026 With LOCK_CNT=1 or FAULT_CNT=1, a single vector SHALL move IDLE directly to LOCKED or FAULT.
REQ-027 err_count SHALL increment by 1 per accepted invalid vector and saturate at 255.
REQ-028 clr SHALL set state=IDLE and zero good_run, bad_run and err_count next edge.
REQ-029 clr SHALL not affect the output register; a pending result still drains.
REQ-030 No vector SHALL be accepted in a clr cycle.

Reset
REQ-031 rst SHALL asynchronously force out_valid=0, out_a=0, out_b=0, out_err=0, state=IDLE, err_count=0 and run counters=0.
REQ-032 A result pending at reset SHALL be discarded.
REQ-033 in_ready SHALL be 1 on the first cycle after rst deasserts (with clr=0).

Structure
REQ-034 A shared package SHALL hold the state encoding enum and the four legal-code constants, for reuse by the gate-vector generator and benches.
REQ-035 Combinational decode SHALL be a sub-module nor_vec_classify: in_vec -> a, b, err.
REQ-036 The FSM, counters and output register SHALL live in the top module.

Verification
REQ-037 After reset, four back-to-back accepts of 11100110, 10001101, 01001101, 00011010 with out_ready=1 -> outputs ab=00,01,10,11, err=0 one cycle after each; state=LOCKED after the 4th.
REQ-038 In LOCKED, send 00000000 twice, then 00011010 -> err=1,1,0; state stays LOCKED; err_count=2.
REQ-039 In LOCKED, send 11111111 three times -> state=FAULT after the 3rd; a following 4 legal vectors leave FAULT; clr -> IDLE, err_count=0.
REQ-040 Hold out_ready=0 with in_valid=1 -> one result captured, in_ready=0, out_* stable; releasing out_ready gives one transfer per cycle with no loss.
REQ-041 300 invalid vectors -> err_count=255 (saturated).
REQ-042 Assert rst mid-stream with out_valid=1 -> out_valid=0 and state=IDLE immediately (asynchronous); assert clr and in_valid together -> in_ready=0, vector not consumed.

Source files
------------

// File: rtl/nor_vector_decoder_pkg.sv
// nor_vector_decoder_pkg: shared FSM state encoding and the four legal gate-result codes (y0..y7 left to right)
package nor_vector_decoder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;
  localparam logic [0:7] CODE_AB00 = 8'b11100110;
  localparam logic [0:7] CODE_AB01 = 8'b10001101;
  localparam logic [0:7] CODE_AB10 = 8'b01001101;
  localparam logic [0:7] CODE_AB11 = 8'b00011010;
endpackage

// File: rtl/nor_vec_classify.sv
// nor_vec_classify: recovers operands from a gate-result vector and flags illegal codes
module nor_vec_classify
  import nor_vector_decoder_pkg::*;
(
  input  logic [0:7] in_vec,
  output logic       a,
  output logic       b,
  output logic       err
);
  // y0 = ~a and y1 = ~b hold for every legal code, so illegal vectors decode the same way
  assign a   = ~in_vec[0];
  assign b   = ~in_vec[1];
  assign err = !(in_vec inside {CODE_AB00, CODE_AB01, CODE_AB10, CODE_AB11});
endmodule

// File: rtl/nor_vector_decoder.sv
// nor_vector_decoder: registered gate-vector decoder with lock/fault tracking and error counting
module nor_vector_decoder
  import nor_vector_decoder_pkg::*;
#(
  parameter int LOCK_CNT  = 4,
  parameter int FAULT_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_a,
  output logic       out_b,
  output logic       out_err,
  output logic [1:0] state,
  output logic [7:0] err_count
);
  localparam logic [3:0] LOCK_TH  = 4'(LOCK_CNT);
  localparam logic [3:0] FAULT_TH = 4'(FAULT_CNT);
  state_t     state_q, state_d;
  logic [3:0] good_run, bad_run, good_d, bad_d;
  logic [7:0] err_count_q, err_count_d;
  logic       cls_a, cls_b, cls_err, accept;
  nor_vec_classify u_classify (
    .in_vec (in_vec),
    .a      (cls_a),
    .b      (cls_b),
    .err    (cls_err)
  );
  assign in_ready  = !clr && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign state     = state_q;
  assign err_count = err_count_q;
  always_comb begin
    state_d     = state_q;
    good_d      = good_run;
    bad_d       = bad_run;
    err_count_d = err_count_q;
    if (clr) begin
      state_d     = ST_IDLE;
      good_d      = '0;
      bad_d       = '0;
      err_count_d = '0;
    end else if (accept) begin
      good_d      = cls_err ? '0 : (good_run == 4'hf ? good_run : good_run + 4'd1);
      bad_d       = !cls_err ? '0 : (bad_run == 4'hf ? bad_run : bad_run + 4'd1);
      err_count_d = (cls_err && err_count_q != 8'hff) ? err_count_q + 8'd1 : err_count_q;
      // thresholds use the updated runs, so a single vector can go straight from IDLE to LOCKED/FAULT
      if (state_q != ST_FAULT)
        state_d = bad_d >= FAULT_TH ? ST_FAULT :
                  (state_q == ST_LOCKED || good_d >= LOCK_TH) ? ST_LOCKED : ST_SYNC;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      good_run    <= '0;
      bad_run     <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_run    <= good_d;
      bad_run     <= bad_d;
      err_count_q <= err_count_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= 1'b0;
      out_b     <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= cls_a;
      out_b     <= cls_b;
      out_err   <= cls_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nor_vector_decoder.sv
// tb_nor_vector_decoder: directed-vector self-checking bench for nor_vector_decoder
module tb_nor_vector_decoder;
  logic       clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [0:7] in_vec = '0;
  logic       in_ready, out_valid, out_a, out_b, out_err;
  logic [1:0] state;
  logic [7:0] err_count;
  int         tests = 0, fails = 0;
  logic [0:7] codes [4] = '{8'b11100110, 8'b10001101, 8'b01001101, 8'b00011010};
  always #5 clk = ~clk;
  nor_vector_decoder #(.LOCK_CNT(4), .FAULT_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_err   (out_err),
    .state     (state),
    .err_count (err_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [0:7] v);
    in_vec   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  initial begin
    repeat (2) step();
    check("rst_out", {out_valid, out_a, out_b, out_err}, 4'b0000);
    check("rst_state", state, 2'd0);
    check("rst_errcnt", err_count, 8'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    // four legal codes back to back: ab = 00,01,10,11
    for (int i = 0; i < 4; i++) begin
      in_vec   = codes[i];
      in_valid = 1'b1;
      step();
      check("legal_out", {out_valid, out_a, out_b, out_err}, {1'b1, 2'(i), 1'b0});
      check("legal_state", state, i < 3 ? 2'd1 : 2'd2);
    end
    in_valid = 1'b0;
    // isolated invalid vectors keep LOCKED
    send(8'b00000000);
    check("inv1_out", {out_valid, out_a, out_b, out_err}, 4'b1111);
    send(8'b00000000);
    check("inv2_out", {out_valid, out_a, out_b, out_err}, 4'b1111);
    check("inv2_state", state, 2'd2);
    send(8'b00011010);
    check("rec_out", {out_valid, out_a, out_b, out_err}, 4'b1110);
    check("rec_state", state, 2'd2);
    check("rec_errcnt", err_count, 8'd2);
    // three invalid in a row -> FAULT, sticky
    send(8'hff);
    send(8'hff);
    check("ff2_state", state, 2'd2);
    send(8'hff);
    check("ff3_out", {out_valid, out_a, out_b, out_err}, 4'b1001);
    check("ff3_state", state, 2'd3);
    for (int i = 0; i < 4; i++) send(codes[i]);
    check("fault_sticky", state, 2'd3);
    check("fault_errcnt", err_count, 8'd5);
    // clr together with in_valid: nothing consumed, result drains
    clr      = 1'b1;
    in_valid = 1'b1;
    in_vec   = 8'hff;
    #1;
    check("clr_in_ready", in_ready, 1'b0);
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_state", state, 2'd0);
    check("clr_errcnt", err_count, 8'd0);
    check("clr_drain", out_valid, 1'b0);
    // backpressure
    out_ready = 1'b0;
    in_vec    = codes[1];
    in_valid  = 1'b1;
    step();
    check("bp_cap", {out_valid, out_a, out_b, out_err}, 4'b1010);
    check("bp_ready", in_ready, 1'b0);
    in_vec = codes[2];
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", {out_valid, out_a, out_b, out_err}, 4'b1010);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    step();
    check("bp_x1", {out_valid, out_a, out_b, out_err}, 4'b1100);
    in_vec = codes[3];
    step();
    check("bp_x2", {out_valid, out_a, out_b, out_err}, 4'b1110);
    in_valid = 1'b0;
    step();
    check("bp_empty", out_valid, 1'b0);
    check("bp_state", state, 2'd1);
    // err_count saturation
    clr = 1'b1;
    step();
    clr      = 1'b0;
    in_vec   = 8'hff;
    in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    check("sat_errcnt", err_count, 8'd255);
    check("sat_state", state, 2'd3);
    step();
    // async reset with a pending result
    out_ready = 1'b0;
    send(codes[2]);
    check("pend_out", {out_valid, out_a, out_b, out_err}, 4'b1100);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out", {out_valid, out_a, out_b, out_err}, 4'b0000);
    check("arst_state", state, 2'd0);
    check("arst_errcnt", err_count, 8'd0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
